// File: rtl/gfx_arb_pkg.sv
// Shared types and pick functions for the gfx Wishbone master arbiter.
package gfx_arb_pkg;

  localparam int MAX_MASTERS = 8;
  localparam int MAX_IDX_W   = 3;

  typedef logic [MAX_MASTERS-1:0] mvec_t;
  typedef logic [MAX_IDX_W-1:0]   midx_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Highest-index requester wins; later hits overwrite earlier ones.
  function automatic mvec_t fp_pick(input mvec_t req);
    mvec_t win;
    win = '0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (req[midx_t'(i)]) begin
        win = '0;
        win[midx_t'(i)] = 1'b1;
      end
    end
    return win;
  endfunction

  // First requester found searching ptr+1 .. ptr+n, wrapping modulo n.
  function automatic mvec_t rr_pick(input mvec_t req, input midx_t ptr, input int n);
    mvec_t win;
    midx_t idx;
    logic  found;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_MASTERS; k++) begin
      if (k <= n) begin
        idx = midx_t'((int'(ptr) + k) % n);
        if (!found && req[idx]) begin
          win[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    return win;
  endfunction

  // One-hot to binary index; zero input maps to index 0.
  function automatic midx_t onehot_to_idx(input mvec_t oh);
    midx_t idx;
    idx = '0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (oh[midx_t'(i)]) idx = idx | midx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/gfx_arb_picker.sv
// Combinational winner select: fixed priority or round-robin from rr_ptr.
module gfx_arb_picker
  import gfx_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int RR_MODE = 0,
  parameter int IDX_W   = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     win
);

  mvec_t req_ext;
  mvec_t pick;
  logic  unused_bits;

  // Widen to the package vector width, pick, then narrow back to N.
  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    if (RR_MODE != 0) pick = rr_pick(req_ext, midx_t'(rr_ptr), N);
    else              pick = fp_pick(req_ext);
    win = pick[N-1:0];
  end

  // Upper pick bits are always zero; rr_ptr is ignored in fixed-priority mode.
  assign unused_bits = |{pick >> N, rr_ptr};

endmodule

// File: rtl/gfx_wbm_rr_arbiter.sv
// N-master to 1-slave Wishbone arbiter with locked grant and optional watchdog.
module gfx_wbm_rr_arbiter
  import gfx_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter int SEL_W       = 4,
  parameter int RR_MODE     = 0,
  parameter int TIMEOUT     = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_MASTERS-1:0]        m_req_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
  input  logic [NUM_MASTERS*SEL_W-1:0]  m_sel_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_dat_i,
  output logic [DATA_W-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic [NUM_MASTERS-1:0]        grant_o,
  output logic                          busy_o,
  output logic                          read_request_o,
  output logic                          write_request_o,
  output logic [ADDR_W-1:0]             addr_o,
  output logic [SEL_W-1:0]              sel_o,
  output logic                          we_o,
  output logic [DATA_W-1:0]             dat_o,
  input  logic [DATA_W-1:0]             dat_i,
  input  logic                          ack_i
);

  localparam int IDX_W  = $clog2(NUM_MASTERS);
  localparam int WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = (TIMEOUT > 0) ? WDOG_W'(TIMEOUT - 1) : '0;

  arb_state_e             state;
  logic [NUM_MASTERS-1:0] grant;
  logic [NUM_MASTERS-1:0] win;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       g_idx;
  logic [WDOG_W-1:0]      wdog;
  logic                   owner_req;
  logic                   timeout_hit;
  mvec_t                  grant_ext;

  gfx_arb_picker #(
    .N       (NUM_MASTERS),
    .RR_MODE (RR_MODE),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (m_req_i),
    .rr_ptr (rr_ptr),
    .win    (win)
  );

  // Index of the current owner, used to move the round-robin pointer.
  always_comb begin
    grant_ext                  = '0;
    grant_ext[NUM_MASTERS-1:0] = grant;
    g_idx                      = IDX_W'(onehot_to_idx(grant_ext));
  end

  // Watchdog expiry only counts while the owner is still requesting.
  assign owner_req   = |(m_req_i & grant);
  assign timeout_hit = (TIMEOUT > 0) && (state == ST_GRANT) && (wdog == WDOG_LAST) && owner_req;

  // Grant FSM: release on ack, then withdrawal, then watchdog expiry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= ST_IDLE;
      grant  <= '0;
      rr_ptr <= IDX_W'(NUM_MASTERS - 1);
      wdog   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|m_req_i) begin
            state <= ST_GRANT;
            grant <= win;
            wdog  <= '0;
          end
        end
        ST_GRANT: begin
          if (ack_i || timeout_hit) begin
            state <= ST_IDLE;
            grant <= '0;
            if (RR_MODE != 0) rr_ptr <= g_idx;
          end else if (!owner_req) begin
            state <= ST_IDLE;
            grant <= '0;
          end else if (wdog != '1) begin
            wdog <= wdog + 1'b1;
          end
        end
      endcase
    end
  end

  // Slave-side mux from the grant register and the owner's live inputs.
  always_comb begin
    addr_o = '0;
    sel_o  = '0;
    we_o   = 1'b0;
    dat_o  = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant[k]) begin
        addr_o = m_addr_i[k*ADDR_W +: ADDR_W];
        sel_o  = m_sel_i[k*SEL_W +: SEL_W];
        we_o   = m_we_i[k];
        dat_o  = m_dat_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign grant_o         = grant;
  assign read_request_o  = (|grant) & ~we_o;
  assign write_request_o = (|grant) & we_o;
  assign m_dat_o         = dat_i;
  assign m_ack_o         = grant & {NUM_MASTERS{ack_i}};
  assign m_err_o         = grant & {NUM_MASTERS{timeout_hit & ~ack_i}};
  assign busy_o          = (|m_req_i) | (state != ST_IDLE);

endmodule

// File: tb/tb_gfx_wbm_rr_arbiter.sv
// Bench for gfx_wbm_rr_arbiter: fixed-priority (TIMEOUT=8) and round-robin (TIMEOUT=0) instances.
`timescale 1ns/1ps
module tb_gfx_wbm_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int NI = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]    req, we;
  logic [N*AW-1:0] addr;
  logic [N*SW-1:0] sel;
  logic [N*DW-1:0] wdat;
  logic [DW-1:0]   sdat;
  logic            ack;

  logic [DW-1:0] d_mdat [NI];
  logic [N-1:0]  d_ack  [NI];
  logic [N-1:0]  d_err  [NI];
  logic [N-1:0]  d_grant[NI];
  logic          d_busy [NI];
  logic          d_rreq [NI];
  logic          d_wreq [NI];
  logic [AW-1:0] d_addr [NI];
  logic [SW-1:0] d_sel  [NI];
  logic          d_we   [NI];
  logic [DW-1:0] d_dat  [NI];

  int n_chk  = 0;
  int n_fail = 0;
  int owner[NI];
  int age  [NI];
  int last [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    gfx_wbm_rr_arbiter #(
      .NUM_MASTERS (N), .ADDR_W (AW), .DATA_W (DW), .SEL_W (SW),
      .RR_MODE (gi), .TIMEOUT ((gi == 0) ? 8 : 0)
    ) u_dut (
      .clk_i (clk), .rst_ni (rst_n),
      .m_req_i (req), .m_we_i (we), .m_addr_i (addr), .m_sel_i (sel), .m_dat_i (wdat),
      .m_dat_o (d_mdat[gi]), .m_ack_o (d_ack[gi]), .m_err_o (d_err[gi]), .grant_o (d_grant[gi]),
      .busy_o (d_busy[gi]), .read_request_o (d_rreq[gi]), .write_request_o (d_wreq[gi]),
      .addr_o (d_addr[gi]), .sel_o (d_sel[gi]), .we_o (d_we[gi]), .dat_o (d_dat[gi]),
      .dat_i (sdat), .ack_i (ack)
    );
  end

  function automatic int tmo_of(input int i);
    return (i == 0) ? 8 : 0;
  endfunction

  function automatic bit rr_of(input int i);
    return (i == 1);
  endfunction

  function automatic int fp_model(input logic [N-1:0] r);
    int w;
    w = -1;
    for (int k = 0; k < N; k++) if (((r >> k) & 1) != 0) w = k;
    return w;
  endfunction

  function automatic int rr_model(input logic [N-1:0] r, input int lst);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (lst + k) % N;
      if (((r >> j) & 1) != 0) return j;
    end
    return -1;
  endfunction

  function automatic int oh2i(input logic [N-1:0] oh);
    int v;
    v = -1;
    for (int k = 0; k < N; k++) if (((oh >> k) & 1) != 0) v = k;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner index, age of the current grant, last completed owner.
  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      logic [N-1:0]  eg, ea, ee;
      logic [AW-1:0] eaddr;
      logic [SW-1:0] esel;
      logic [DW-1:0] edat;
      logic          ewe;
      bit            wd;
      bit            expire;
      int            o;
      if (!rst_n) begin
        owner[i] = -1;
        age[i]   = 0;
        last[i]  = N - 1;
      end
      o = owner[i];
      eg = '0; ea = '0; ee = '0; eaddr = '0; esel = '0; edat = '0; ewe = 1'b0;
      wd = 1'b0; expire = 1'b0;
      if (o >= 0) begin
        eg     = N'(1 << o);
        eaddr  = addr[o*AW +: AW];
        esel   = sel[o*SW +: SW];
        edat   = wdat[o*DW +: DW];
        ewe    = ((we >> o) & 1) != 0;
        wd     = ((req >> o) & 1) == 0;
        expire = (tmo_of(i) != 0) && (age[i] == tmo_of(i) - 1) && !wd;
        if (ack) ea = eg;
        else if (expire) ee = eg;
      end
      chk($sformatf("u%0d_grant", i), d_grant[i], eg);
      chk($sformatf("u%0d_ack", i), d_ack[i], ea);
      chk($sformatf("u%0d_err", i), d_err[i], ee);
      chk($sformatf("u%0d_busy", i), d_busy[i], (req != 0) || (o >= 0));
      chk($sformatf("u%0d_rreq", i), d_rreq[i], (o >= 0) && !ewe);
      chk($sformatf("u%0d_wreq", i), d_wreq[i], (o >= 0) && ewe);
      chk($sformatf("u%0d_addr", i), d_addr[i], eaddr);
      chk($sformatf("u%0d_sel", i), d_sel[i], esel);
      chk($sformatf("u%0d_we", i), d_we[i], ewe);
      chk($sformatf("u%0d_dat", i), d_dat[i], edat);
      chk($sformatf("u%0d_mdat", i), d_mdat[i], sdat);
      if (rst_n) begin
        if (o < 0) begin
          if (req != 0) begin
            owner[i] = rr_of(i) ? rr_model(req, last[i]) : fp_model(req);
            age[i]   = 0;
          end
        end else if (ack || expire) begin
          if (rr_of(i)) last[i] = o;
          owner[i] = -1;
        end else if (wd) begin
          owner[i] = -1;
        end else begin
          age[i]++;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    int exp_order[5];
    int found, got;
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NI; i++) begin owner[i] = -1; age[i] = 0; last[i] = N - 1; end
    rst_n = 1'b0; req = '0; we = '0; addr = '0; sel = '0; wdat = '0; sdat = '0; ack = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // Fixed priority pick, one-cycle grant latency, combinational ack.
    req = 4'b1011;
    smp(); chk("t1_idle_grant", d_grant[0], 4'b0000);
    cyc(); smp(); chk("t1_fp_grant", d_grant[0], 4'b1000);
    chk("t1_rr_first_grant", d_grant[1], 4'b0001);
    cyc();
    cyc(); ack = 1'b1;
    smp(); chk("t1_fp_ack", d_ack[0], 4'b1000);
    chk("t1_rr_ack", d_ack[1], 4'b0001);
    cyc(); ack = 1'b0; req = '0;
    smp(); chk("t1_release", d_grant[0], 4'b0000);

    // Round-robin rotation with wrap from N-1 back to 0.
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1; req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      found = 0; got = -1;
      for (int w = 0; w < 12 && found == 0; w++) begin
        smp();
        if (d_grant[1] != 0) begin found = 1; got = oh2i(d_grant[1]); end
        else cyc();
      end
      chk("t2_grant_seen", found, 1);
      chk($sformatf("t2_order%0d", n), got, exp_order[n]);
      cyc(); ack = 1'b1;
      cyc(); ack = 1'b0;
    end
    req = '0;
    cyc(); cyc();

    // Write routing for master 2, then read once we drops.
    req = 4'b0100; we = 4'b0100;
    addr[2*AW +: AW] = 30'h100; sel[2*SW +: SW] = 4'h3; wdat[2*DW +: DW] = 32'hDEADBEEF;
    cyc(); smp();
    chk("t3_wreq", d_wreq[0], 1);
    chk("t3_rreq", d_rreq[0], 0);
    chk("t3_addr", d_addr[0], 30'h100);
    chk("t3_sel", d_sel[0], 4'h3);
    chk("t3_dat", d_dat[0], 32'hDEADBEEF);
    chk("t3_we", d_we[0], 1);
    cyc(); we = '0;
    smp(); chk("t3_we_read", d_we[0], 0);
    chk("t3_rreq_read", d_rreq[0], 1);
    cyc(); ack = 1'b1;
    cyc(); ack = 1'b0; req = '0;
    cyc();

    // Watchdog expiry on the 8th granted cycle, then ack winning over expiry.
    req = 4'b0001;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      if (c == 9) req = '0;
      smp();
      if (c == 7) chk("t4_err_early", d_err[0], 4'b0000);
      if (c == 8) begin
        chk("t4_err_pulse", d_err[0], 4'b0001);
        chk("t4_grant_held", d_grant[0], 4'b0001);
      end
      if (c == 9) chk("t4_released", d_grant[0], 4'b0000);
    end
    cyc(); req = 4'b0001;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      if (c == 8) ack = 1'b1;
      smp();
      if (c == 8) begin
        chk("t4_ack_wins", d_ack[0], 4'b0001);
        chk("t4_no_err", d_err[0], 4'b0000);
      end
    end
    cyc(); ack = 1'b0; req = '0;
    cyc();

    // Withdrawal: release without ack or err, pending master granted after.
    req = 4'b1001;
    cyc();
    cyc(); req = 4'b0001;
    smp(); chk("t5_no_ack", d_ack[0], 4'b0000);
    chk("t5_no_err", d_err[0], 4'b0000);
    cyc(); smp(); chk("t5_idle", d_grant[0], 4'b0000);
    cyc(); smp(); chk("t5_next_grant", d_grant[0], 4'b0001);
    cyc(); ack = 1'b1;
    cyc(); ack = 1'b0; req = '0;
    cyc();

    // Asynchronous reset mid-grant.
    req = 4'b0010; we = 4'b0010;
    cyc(); smp(); chk("t6_granted", d_grant[0], 4'b0010);
    cyc(); ack = 1'b1; rst_n = 1'b0;
    #1;
    chk("t6_grant_drop", d_grant[0], 4'b0000);
    chk("t6_wreq_drop", d_wreq[0], 0);
    chk("t6_rreq_drop", d_rreq[0], 0);
    chk("t6_ack_blocked", d_ack[0], 4'b0000);
    chk("t6_rr_ack_blocked", d_ack[1], 4'b0000);
    cyc(); ack = 1'b0; req = 4'b1111; we = '0; rst_n = 1'b1;
    cyc(); smp();
    chk("t6_rr_restart", d_grant[1], 4'b0001);
    chk("t6_fp_restart", d_grant[0], 4'b1000);
    cyc(); ack = 1'b1;
    cyc(); ack = 1'b0; req = '0;
    cyc();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      cyc();
      rst_n = ($urandom_range(0, 599) != 0);
      for (int k = 0; k < N; k++) begin
        if (req[k]) begin
          if ($urandom_range(0, 15) == 0) req[k] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[k] = 1'b1;
        end
        we[k]             = 1'($urandom_range(0, 1));
        addr[k*AW +: AW]  = AW'($urandom);
        sel[k*SW +: SW]   = SW'($urandom);
        wdat[k*DW +: DW]  = $urandom;
      end
      ack  = ($urandom_range(0, 3) == 0);
      sdat = $urandom;
    end
    cyc(); rst_n = 1'b1; req = '0; ack = 1'b0;
    cyc(); cyc();
    smp();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
